// File: rtl/div_issuer_pkg.sv
// Shared widths, special constants and FSM encoding for the divide issuer.
// Included by the interface, the sign fix-up block and the issuer top.
package div_issuer_pkg;

    localparam int LEN_WORD     = 32;
    localparam int LEN_REG_ADDR = 5;

    localparam logic [LEN_WORD-1:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [LEN_WORD-1:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Two's-complement negate; INT_MIN negates to itself, which is the
    // magnitude the unsigned divider needs.
    function automatic logic [LEN_WORD-1:0] neg_word(input logic [LEN_WORD-1:0] v);
        return ~v + LEN_WORD'(1);
    endfunction

endpackage

// File: rtl/div_issuer_if.sv
// Request, divider and writeback signal bundle for div_issuer.
// master = the issuer itself, slave = the core/divider/writeback environment.
interface div_issuer_if;
    import div_issuer_pkg::*;

    // Every valid/ready pair (req, wb) transfers on a rising clock edge where
    // both are high; the sender holds valid and payload stable until then.
    // The divider uses order/accepted, then reports completion with done.
    logic                    req_valid;
    logic                    req_ready;
    logic [LEN_WORD-1:0]     req_rs1;
    logic [LEN_WORD-1:0]     req_rs2;
    logic                    req_unsig;
    logic                    req_rem;
    logic [LEN_REG_ADDR-1:0] req_rd;

    logic                    div_order;
    logic                    div_accepted;
    logic                    div_done;
    logic [LEN_WORD-1:0]     div_rs1;
    logic [LEN_WORD-1:0]     div_rs2;
    logic                    div_unsig;
    logic                    div_rem_flag;
    logic [LEN_WORD-1:0]     div_result;

    logic                    wb_valid;
    logic                    wb_ready;
    logic [LEN_REG_ADDR-1:0] wb_rd;
    logic [LEN_WORD-1:0]     wb_data;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_unsig, req_rem, req_rd,
        output req_ready,
        output div_order, div_rs1, div_rs2, div_unsig, div_rem_flag,
        input  div_accepted, div_done, div_result,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_unsig, req_rem, req_rd,
        input  req_ready,
        input  div_order, div_rs1, div_rs2, div_unsig, div_rem_flag,
        output div_accepted, div_done, div_result,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready
    );

endinterface

// File: rtl/div_sign_fix.sv
// Converts signed operands to unsigned magnitudes for the divider and
// restores the sign of the returned quotient or remainder.
module div_sign_fix
    import div_issuer_pkg::*;
(
    input  logic [LEN_WORD-1:0] rs1,
    input  logic [LEN_WORD-1:0] rs2,
    input  logic                unsig,
    input  logic                rem,
    input  logic [LEN_WORD-1:0] raw_result,
    output logic [LEN_WORD-1:0] mag_rs1,
    output logic [LEN_WORD-1:0] mag_rs2,
    output logic [LEN_WORD-1:0] fixed_result
);

    logic negate;

    always_comb begin
        mag_rs1 = (!unsig && rs1[LEN_WORD-1]) ? neg_word(rs1) : rs1;
        mag_rs2 = (!unsig && rs2[LEN_WORD-1]) ? neg_word(rs2) : rs2;
        // Remainder follows the dividend; quotient is negative iff signs differ.
        if (rem) begin
            negate = !unsig && rs1[LEN_WORD-1];
        end else begin
            negate = !unsig && (rs1[LEN_WORD-1] ^ rs2[LEN_WORD-1]);
        end
        fixed_result = negate ? neg_word(raw_result) : raw_result;
    end

endmodule

// File: rtl/div_issuer.sv
// Accepts a divide request, resolves divide-by-zero and signed overflow locally,
// otherwise issues unsigned magnitudes to the divider and writes back the result.
module div_issuer
    import div_issuer_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    div_issuer_if.master bus,
    output logic         busy,
    output state_t       state_dbg
);

    state_t                  state_q;
    state_t                  state_d;
    logic                    live_q;
    logic [LEN_WORD-1:0]     rs1_q;
    logic [LEN_WORD-1:0]     rs2_q;
    logic                    unsig_q;
    logic                    rem_q;
    logic [LEN_REG_ADDR-1:0] rd_q;
    logic [LEN_WORD-1:0]     result_q;

    logic                    req_fire;
    logic                    div_zero;
    logic                    sig_ovf;
    logic                    special;
    logic [LEN_WORD-1:0]     special_result;
    logic                    done_fire;
    logic [LEN_WORD-1:0]     mag_rs1;
    logic [LEN_WORD-1:0]     mag_rs2;
    logic [LEN_WORD-1:0]     fixed_result;

    div_sign_fix u_sign_fix (
        .rs1          (rs1_q),
        .rs2          (rs2_q),
        .unsig        (unsig_q),
        .rem          (rem_q),
        .raw_result   (bus.div_result),
        .mag_rs1      (mag_rs1),
        .mag_rs2      (mag_rs2),
        .fixed_result (fixed_result)
    );

    assign req_fire = bus.req_valid && bus.req_ready;
    assign div_zero = (bus.req_rs2 == '0);
    assign sig_ovf  = !bus.req_unsig && (bus.req_rs1 == INT_MIN) && (bus.req_rs2 == ALL_ONES);
    assign special  = div_zero || sig_ovf;

    always_comb begin
        if (div_zero) begin
            special_result = bus.req_rem ? bus.req_rs1 : ALL_ONES;
        end else begin
            special_result = bus.req_rem ? '0 : INT_MIN;
        end
    end

    // A done pulse only counts once the divider has taken the order.
    assign done_fire = bus.div_done &&
                       ((state_q == ST_WAIT) || ((state_q == ST_ISSUE) && bus.div_accepted));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) state_d = special ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.div_accepted) state_d = bus.div_done ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.div_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.wb_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // live_q keeps req_ready low while reset is held and for no longer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_q   <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            unsig_q  <= 1'b0;
            rem_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            live_q <= 1'b1;
            if ((state_q == ST_IDLE) && req_fire) begin
                rs1_q   <= bus.req_rs1;
                rs2_q   <= bus.req_rs2;
                unsig_q <= bus.req_unsig;
                rem_q   <= bus.req_rem;
                rd_q    <= bus.req_rd;
                if (special) result_q <= special_result;
            end
            if (done_fire) result_q <= fixed_result;
        end
    end

    // Payload outputs are gated to their owning state so idle buses read zero.
    assign bus.req_ready    = live_q && (state_q == ST_IDLE);
    assign bus.div_order    = (state_q == ST_ISSUE);
    assign bus.div_rs1      = (state_q == ST_ISSUE) ? mag_rs1 : '0;
    assign bus.div_rs2      = (state_q == ST_ISSUE) ? mag_rs2 : '0;
    assign bus.div_unsig    = (state_q == ST_ISSUE);
    assign bus.div_rem_flag = (state_q == ST_ISSUE) && rem_q;
    assign bus.wb_valid     = (state_q == ST_RESP);
    assign bus.wb_rd        = (state_q == ST_RESP) ? rd_q : '0;
    assign bus.wb_data      = (state_q == ST_RESP) ? result_q : '0;
    assign busy             = (state_q != ST_IDLE);
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_div_issuer.sv
// Directed bench for div_issuer: normal and special divides, stalled handshakes
// and reset during an outstanding divide.
module tb_div_issuer;
  import div_issuer_pkg::*;

  logic   clk = 1'b0;
  logic   rstn;
  logic   busy;
  state_t state_dbg;

  div_issuer_if bus();

  div_issuer dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_rs1      = '0;
    bus.req_rs2      = '0;
    bus.req_unsig    = 1'b0;
    bus.req_rem      = 1'b0;
    bus.req_rd       = '0;
    bus.div_accepted = 1'b0;
    bus.div_done     = 1'b0;
    bus.div_result   = '0;
    bus.wb_ready     = 1'b0;
  endtask

  task automatic send_req(input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic unsig, input logic rem, input logic [4:0] rd);
    check_eq("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_unsig = unsig;
    bus.req_rem   = rem;
    bus.req_rd    = rd;
    tick();
    bus.req_valid = 1'b0;
    bus.req_rs1   = 32'hDEAD_BEEF;
    bus.req_rs2   = 32'hDEAD_BEEF;
  endtask

  task automatic drain_wb(input string name, input logic [4:0] rd, input int wb_delay);
    logic [31:0] exp_data;
    exp_data = exp_q.pop_front();
    check_eq({name, "_wb_valid"}, bus.wb_valid, 1);
    check_eq({name, "_wb_data"}, bus.wb_data, exp_data);
    check_eq({name, "_wb_rd"}, bus.wb_rd, rd);
    for (int k = 0; k < wb_delay; k++) begin
      tick();
      check_eq({name, "_wb_hold_valid"}, bus.wb_valid, 1);
      check_eq({name, "_wb_hold_data"}, bus.wb_data, exp_data);
      check_eq({name, "_wb_hold_rd"}, bus.wb_rd, rd);
      check_eq({name, "_wb_hold_req_ready"}, bus.req_ready, 0);
    end
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    check_eq({name, "_wb_released"}, bus.wb_valid, 0);
    check_eq({name, "_back_idle"}, bus.req_ready, 1);
  endtask

  // Divider model: answers from the operands the bench expects to see;
  // latency 0 means accepted and done in the same cycle.
  task automatic run_normal(input string name, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic unsig, input logic rem, input logic [4:0] rd,
                            input logic [31:0] exp_mag1, input logic [31:0] exp_mag2,
                            input logic [31:0] exp_data,
                            input int acc_delay, input int latency, input int wb_delay);
    logic [31:0] r;
    r = rem ? (exp_mag1 % exp_mag2) : (exp_mag1 / exp_mag2);
    exp_q.push_back(exp_data);
    send_req(rs1, rs2, unsig, rem, rd);
    check_eq({name, "_order"}, bus.div_order, 1);
    check_eq({name, "_div_rs1"}, bus.div_rs1, exp_mag1);
    check_eq({name, "_div_rs2"}, bus.div_rs2, exp_mag2);
    check_eq({name, "_div_unsig"}, bus.div_unsig, 1);
    check_eq({name, "_div_rem_flag"}, bus.div_rem_flag, rem);
    for (int k = 0; k < acc_delay; k++) begin
      tick();
      check_eq({name, "_order_hold"}, bus.div_order, 1);
      check_eq({name, "_rs1_hold"}, bus.div_rs1, exp_mag1);
      check_eq({name, "_rs2_hold"}, bus.div_rs2, exp_mag2);
      check_eq({name, "_rem_hold"}, bus.div_rem_flag, rem);
      check_eq({name, "_req_ready_low"}, bus.req_ready, 0);
    end
    bus.div_accepted = 1'b1;
    if (latency == 0) begin
      bus.div_done   = 1'b1;
      bus.div_result = r;
    end
    tick();
    bus.div_accepted = 1'b0;
    if (latency > 0) begin
      check_eq({name, "_order_dropped"}, bus.div_order, 0);
      for (int k = 1; k < latency; k++) begin
        tick();
        check_eq({name, "_wait_no_wb"}, bus.wb_valid, 0);
      end
      bus.div_done   = 1'b1;
      bus.div_result = r;
      check_eq({name, "_no_wb_before_done"}, bus.wb_valid, 0);
      tick();
    end
    bus.div_done   = 1'b0;
    bus.div_result = '0;
    drain_wb(name, rd, wb_delay);
  endtask

  task automatic run_special(input string name, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic unsig, input logic rem, input logic [4:0] rd,
                             input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    send_req(rs1, rs2, unsig, rem, rd);
    check_eq({name, "_no_order"}, bus.div_order, 0);
    check_eq({name, "_busy"}, busy, 1);
    drain_wb(name, rd, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_div_order", bus.div_order, 0);
    check_eq("rst_div_unsig", bus.div_unsig, 0);
    check_eq("rst_wb_valid", bus.wb_valid, 0);
    check_eq("rst_wb_data", bus.wb_data, 0);
    check_eq("rst_state", state_dbg, ST_IDLE);
    rstn = 1'b1;
    tick();
    check_eq("rst_release_ready", bus.req_ready, 1);

    run_normal("u100d7_q", 32'd100, 32'd7, 1'b1, 1'b0, 5'd5, 32'd100, 32'd7, 32'd14, 0, 8, 0);
    run_normal("u100d7_r", 32'd100, 32'd7, 1'b1, 1'b1, 5'd6, 32'd100, 32'd7, 32'd2, 0, 8, 0);
    run_normal("sm7d2_q", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 5'd7, 32'd7, 32'd2, 32'hFFFF_FFFD, 1, 2, 0);
    run_normal("sm7d2_r", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 5'd8, 32'd7, 32'd2, 32'hFFFF_FFFF, 0, 3, 0);
    run_special("udz_q", 32'h1234_5678, 32'd0, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF);
    run_special("udz_r", 32'h1234_5678, 32'd0, 1'b1, 1'b1, 5'd10, 32'h1234_5678);
    run_special("sdz_r", 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 5'd11, 32'hFFFF_FFF0);
    run_special("sovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd12, 32'h8000_0000);
    run_special("sovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd13, 32'h0000_0000);
    run_normal("stall", 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 5'd14, 32'd100, 32'd7, 32'hFFFF_FFF2, 3, 4, 5);
    run_normal("same_cyc", 32'd50, 32'd5, 1'b1, 1'b0, 5'd15, 32'd50, 32'd5, 32'd10, 1, 0, 0);
    run_normal("u_min_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 0);
    run_normal("s_min_d2", 32'h8000_0000, 32'd2, 1'b0, 1'b0, 5'd17, 32'h8000_0000, 32'd2, 32'hC000_0000, 0, 2, 0);
    run_normal("s_rem_pos", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 5'd18, 32'd7, 32'd2, 32'd1, 0, 2, 1);

    // Reset while the divider owns an accepted order.
    send_req(32'd100, 32'd7, 1'b1, 1'b0, 5'd3);
    bus.div_accepted = 1'b1;
    tick();
    bus.div_accepted = 1'b0;
    tick();
    check_eq("mid_state_wait", state_dbg, ST_WAIT);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", bus.req_ready, 0);
    check_eq("mid_rst_order", bus.div_order, 0);
    check_eq("mid_rst_wb_valid", bus.wb_valid, 0);
    check_eq("mid_rst_wb_data", bus.wb_data, 0);
    tick();
    rstn = 1'b1;
    tick();
    bus.div_done   = 1'b1;
    bus.div_result = 32'd14;
    tick();
    bus.div_done   = 1'b0;
    bus.div_result = '0;
    check_eq("late_done_no_wb", bus.wb_valid, 0);
    check_eq("late_done_idle", busy, 0);
    tick();
    check_eq("late_done_no_wb2", bus.wb_valid, 0);
    run_normal("after_rst", 32'd9, 32'd3, 1'b1, 1'b0, 5'd4, 32'd9, 32'd3, 32'd3, 0, 2, 0);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issuer.md
DIV_ISSUER -- requirements
Module: div_issuer

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports req_valid in 1, req_ready out 1: core request handshake; transfer when both are high.
REQ-004 SHALL have ports req_rs1 in 32 (dividend), req_rs2 in 32 (divisor), req_unsig in 1 (1 = unsigned), req_rem in 1 (1 = remainder, 0 = quotient), req_rd in 5 (destination register).
REQ-005 SHALL have ports div_order out 1, div_accepted in 1, div_done in 1: initiator side of the divider order/accepted/done handshake.
REQ-006 SHALL have ports div_rs1 out 32, div_rs2 out 32, div_unsig out 1, div_rem_flag out 1, div_result in 32: operands sent to the divider and the result returned by it.
REQ-007 SHALL have ports wb_valid out 1, wb_ready in 1, wb_rd out 5, wb_data out 32: writeback handshake; transfer when both are high.
REQ-008 SHALL have port busy out 1: high in every state except IDLE.

Function
REQ-009 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-010 SHALL drive req_ready = 1 only in IDLE.
REQ-011 SHALL, on an IDLE transfer, latch rs1, rs2, unsig, rem and rd.
REQ-012 SHALL, on an IDLE transfer, go to RESP if a special case applies (REQ-018 or REQ-019); otherwise it SHALL go to ISSUE.
REQ-013 SHALL, in ISSUE, hold div_order = 1 and keep div_rs1, div_rs2 and div_rem_flag stable until div_accepted is seen; on div_accepted it SHALL go to WAIT.
REQ-014 SHALL treat div_accepted and div_done high in the same cycle as completion: capture the result and go to RESP.
REQ-015 SHALL, in WAIT, on div_done capture div_result, apply the sign fix-up and go to RESP; div_done SHALL be ignored in IDLE, ISSUE-before-accept and RESP.
REQ-016 SHALL, in RESP, hold wb_valid = 1 with wb_rd and wb_data stable until wb_ready is seen; on wb_ready it SHALL go to IDLE. The next request is accepted no earlier than the following cycle.
REQ-017 SHALL always send unsigned magnitudes to the divider (div_unsig = 1).
  - Signed magnitude = two's-complement absolute value; 0x80000000 maps to 0x80000000.
  - Signed quotient is negated iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
REQ-018 SHALL handle divide-by-zero (rs2 == 0, signed or unsigned) without issuing: quotient = 0xFFFFFFFF, remainder = rs1.
REQ-019 SHALL handle signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, signed) without issuing: quotient = 0x80000000, remainder = 0.
REQ-020 SHALL meet these latencies:
  - Special case: transfer in cycle N gives wb_valid in cycle N+1.
  - Normal case: div_done in cycle M gives wb_valid in cycle M+1.
REQ-021 SHALL never assert div_order outside ISSUE and never drop it in ISSUE before div_accepted.

Reset
REQ-022 SHALL, while rstn = 0, force state to IDLE and all outputs to 0 except req_ready = 0; req_ready SHALL rise to 1 in the first cycle after release.
REQ-023 SHALL, when reset is asserted mid-operation, abandon the operation; a div_done arriving after release SHALL be ignored and SHALL NOT produce wb_valid.

Structure
REQ-024 SHALL take LEN_WORD (32), LEN_REG_ADDR (5), the state encoding and the special constants (0xFFFFFFFF, 0x80000000) from the shared include/package.
REQ-025 SHALL place the magnitude conversion and sign restoration in one combinational sub-module, div_sign_fix, instantiated once.

Verification
REQ-026 SHALL cover unsigned 100/7 against a divider model with 8-cycle latency: quot -> wb_data 14; rem -> 2; div_rs1/div_rs2 = 100/7; wb_valid one cycle after div_done.
REQ-027 SHALL cover signed 0xFFFFFFF9 / 2: divider sees 7/2; quot -> 0xFFFFFFFD; rem -> 0xFFFFFFFF.
REQ-028 SHALL cover 0x12345678 / 0: div_order stays 0; quot -> 0xFFFFFFFF, rem -> 0x12345678, both in cycle N+1; signed 0x80000000 / 0xFFFFFFFF gives quot 0x80000000, rem 0.
REQ-029 SHALL cover a divider that delays div_accepted 3 cycles and wb_ready held low 5 cycles: div_order and operands stable; wb_data and wb_rd stable; req_ready low throughout.
REQ-030 SHALL cover rstn pulsed low during WAIT, followed by a late div_done: outputs 0; no wb_valid; a following 9/3 request returns 3.
